uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- 8-bit UART transmitter for the soc2 peripheral block (u_peri). It is the transmit-side counterpart of the UART receiver.
- Serialises bytes as 8N1 or 8N2 frames on the uart_tx pin, LSB first, at a fixed baud rate derived from the core clock.
- A one-byte holding register sits in front of the shift register, so the CPU-side UART register logic can queue the next byte while the current frame is on the wire. Frames are sent back-to-back.

Parameters:
- CLKS_PER_BIT, 217, core clock cycles per bit period (25 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  core clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid; a byte is accepted on a rising edge where tx_valid && tx_ready.
- tx_ready  output  1  holding register empty; equals ~hold_full (driven straight from a register, no combinational path from tx_valid).
- uart_tx  output  1  serial line, registered output; idles high.
- tx_busy  output  1  high when state != IDLE or hold_full.
- tx_done  output  1  one-cycle pulse in the last clock cycle of each frame's final stop bit.

Behaviour:
- Reset (synchronous, on clk edge with reset=1):
  - state=IDLE, hold_full=0, baud counter=0, bit index=0.
  - Outputs: uart_tx=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Reset mid-frame aborts the frame. uart_tx is 1 after that edge. Any byte in the holding register is discarded. tx_valid is ignored while reset=1.
- Holding register:
  - On accept, tx_data is captured into hold and hold_full goes to 1.
  - hold_full clears on the edge where hold is copied into the shift register.
  - Accept and copy cannot coincide, since accept needs hold_full=0 and copy needs hold_full=1.
- States: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If hold_full, then on the next edge: shift<=hold, hold_full<=0, state<=START, uart_tx<=0, counter<=0.
  - START: uart_tx=0 for CLKS_PER_BIT cycles. When counter==CLKS_PER_BIT-1: state<=DATA, uart_tx<=shift[0], bit index<=0, counter<=0.
  - DATA: each bit is held for CLKS_PER_BIT cycles. At the end of each bit period the register shifts right and the bit index increments. After bit 7: state<=STOP, uart_tx<=1.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 in the final cycle. On the next edge:
    - If hold_full, go directly to START (load shift, uart_tx<=0) with no idle cycle.
    - Otherwise go to IDLE.
- Counter width: ceil(log2(STOP_BITS*CLKS_PER_BIT)) bits. The counter wraps to 0 at the end of each bit period (at the end of the whole stop period in STOP).
- Latency: a byte accepted at edge E into an idle engine gives uart_tx=0 from edge E+1.
- Frame length: exactly (9+STOP_BITS)*CLKS_PER_BIT cycles from the start-bit falling edge to the next start-bit falling edge when back-to-back.
- Holding register full while a frame is in progress: tx_ready=0. The producer must hold tx_valid and tx_data until accepted.
- tx_valid asserted with tx_ready=0: no effect, no data loss. This is the producer's responsibility.

Test Plan:
- Reset, then idle 20 cycles with tx_valid=0 -> uart_tx=1, tx_ready=1, tx_busy=0, tx_done never pulses.
- CLKS_PER_BIT=4, STOP_BITS=1, send 0x5A -> uart_tx sequence per 4-cycle bit: 0, then 0,1,0,1,1,0,1,0, then 1. Falling edge occurs 1 cycle after accept. tx_done pulses once, in cycle 40 of the frame.
- CLKS_PER_BIT=4, send 0x07 then immediately hold tx_valid with 0xA5 -> 0xA5 accepted 1 cycle after 0x07 leaves hold. The second start bit begins exactly 40 cycles after the first. No idle-high gap; tx_busy stays 1 throughout both frames.
- STOP_BITS=2, CLKS_PER_BIT=4, send 0xFF -> start bit 4 cycles low, line high for 32+8 cycles. Frame length is 44 cycles; tx_done occurs in cycle 44.
- Assert reset mid-DATA of 0x55 with 0x33 in the holding register -> after the reset edge uart_tx=1, tx_ready=1, tx_busy=0. 0x33 is never transmitted. A new 0x81 sent afterwards frames correctly.
- Loopback: connect uart_tx to the UART receiver at CLKS_PER_BIT=217, send 0x00, 0xFF, 0x5A -> the receiver's rx_data matches each byte in order, with no framing error.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8N1/8N2 UART transmitter, LSB first, with a one-byte holding
// register in front of the shift register so frames can be sent back-to-back.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 217,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W    = (STOP_LEN > 2) ? $clog2(STOP_LEN) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
  localparam logic [CNT_W-1:0] STOP_PRE  = CNT_W'(STOP_LEN - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             ready_q;
  logic             busy_q;

  // Next-state logic for the holding register and the frame sequencer.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    done_d      = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = S_START;
          tx_d        = 1'b0;
          cnt_d       = CNT_ZERO;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      S_START: begin
        if (cnt_q == BIT_LAST) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          cnt_d     = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = CNT_ZERO;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        // A queued byte starts its start bit straight after the stop period.
        if (cnt_q == STOP_LAST) begin
          cnt_d = CNT_ZERO;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = S_START;
            tx_d        = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          done_d = (cnt_q == STOP_PRE);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame and drops the held byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      cnt_q       <= CNT_ZERO;
      bit_idx_q   <= 3'd0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      ready_q     <= ~hold_full_d;
      busy_q      <= (state_d != S_IDLE) || hold_full_d;
    end
  end

  assign tx_ready = ready_q;
  assign uart_tx  = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: a fast 8N1 instance with random traffic,
// an 8N2 instance, and a 217-clock instance read back by a behavioural receiver.
module tb_uart_tx_engine;

  localparam int A_CPB = 4;
  localparam int A_LEN = 40;
  localparam int B_CPB = 4;
  localparam int B_LEN = 44;
  localparam int C_CPB = 217;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic       reset_a, reset_bc;
  logic [7:0] a_data, b_data, c_data;
  logic       a_valid, b_valid, c_valid;
  logic       a_ready, a_uart, a_busy, a_done;
  logic       b_ready, b_uart, b_busy, b_done;
  logic       c_ready, c_uart, c_busy, c_done;

  uart_tx_engine #(.CLKS_PER_BIT(A_CPB), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .reset(reset_a), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .uart_tx(a_uart), .tx_busy(a_busy), .tx_done(a_done)
  );

  uart_tx_engine #(.CLKS_PER_BIT(B_CPB), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .reset(reset_bc), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .uart_tx(b_uart), .tx_busy(b_busy), .tx_done(b_done)
  );

  uart_tx_engine #(.CLKS_PER_BIT(C_CPB), .STOP_BITS(1)) u_dut_c (
    .clk(clk), .reset(reset_bc), .tx_data(c_data), .tx_valid(c_valid),
    .tx_ready(c_ready), .uart_tx(c_uart), .tx_busy(c_busy), .tx_done(c_done)
  );

  function automatic void chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  // Line level during frame bit idx: 0 start, 1..8 data LSB first, then stop/idle high.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    if (idx < 0 || idx > 9) return 1'b1;
    return fr[idx[3:0]];
  endfunction

  // Reference model state for instance A (cycle numbers count rising edges).
  exp_t sb_a[$];
  int   a_last_e = -1;
  int   a_last_s = -1;
  int   a_sp1 = -1000;
  int   a_sp2 = -1000;
  bit   a_started = 1'b0;
  bit   a_in_frame = 1'b0;
  int   a_j = 0;
  exp_t cur_a;
  logic [7:0] sb_c[$];

  // tx_ready follows the modelled holding register, tx_busy its occupancy or an active frame.
  always @(negedge clk) begin
    if (a_started && !reset_a) begin
      chk("a_ready", int'(a_ready), int'(!((a_last_e <= cyc) && (cyc < a_last_s))));
      chk("a_busy", int'(a_busy),
          int'(((a_last_e <= cyc) && (cyc < a_last_s)) ||
               ((a_sp1 <= cyc) && (cyc < a_sp1 + A_LEN)) ||
               ((a_sp2 <= cyc) && (cyc < a_sp2 + A_LEN))));
    end
  end

  // Monitor A: detect start bits, pop the expected frame, compare every cycle of it.
  always begin
    @(posedge clk);
    #1;
    if (reset_a) begin
      a_in_frame = 1'b0;
      sb_a.delete();
      chk("a_rst_uart", int'(a_uart), 1);
      chk("a_rst_ready", int'(a_ready), 1);
      chk("a_rst_busy", int'(a_busy), 0);
      chk("a_rst_done", int'(a_done), 0);
    end else begin
      if (!a_in_frame && a_uart == 1'b0) begin
        if (sb_a.size() == 0) begin
          chk("a_spurious_start", int'(a_uart), 1);
        end else begin
          cur_a = sb_a.pop_front();
          chk("a_start_cycle", cyc, cur_a.start);
          a_in_frame = 1'b1;
          a_j = 0;
        end
      end
      if (a_in_frame) begin
        chk("a_line", int'(a_uart), int'(frame_bit(cur_a.data, a_j / A_CPB)));
        chk("a_done", int'(a_done), int'(a_j == A_LEN - 1));
        a_j++;
        if (a_j == A_LEN) a_in_frame = 1'b0;
      end else begin
        chk("a_done_idle", int'(a_done), 0);
      end
    end
  end

  task automatic send_a(input logic [7:0] d);
    int t;
    int e;
    int s;
    a_valid = 1'b1;
    a_data  = d;
    t = 0;
    while (a_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      chk("a_accept_timeout", t, 0);
      a_valid = 1'b0;
      return;
    end
    e = cyc + 1;
    s = (e + 1 > a_sp1 + A_LEN) ? e + 1 : a_sp1 + A_LEN;
    sb_a.push_back('{d, s});
    a_last_e = e;
    a_last_s = s;
    a_sp2 = a_sp1;
    a_sp1 = s;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    int t;
    t = 0;
    while ((sb_a.size() != 0 || a_in_frame) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("a_idle_timeout", t, 0);
    @(negedge clk);
  endtask

  task automatic run_a();
    repeat (20) @(negedge clk);
    send_a(8'h5A);
    wait_idle_a();
    send_a(8'h07);
    send_a(8'hA5);
    wait_idle_a();
    send_a(8'h55);
    send_a(8'h33);
    repeat (16) @(negedge clk);
    reset_a  = 1'b1;
    a_last_e = -1;
    a_last_s = -1;
    a_sp1    = -1000;
    a_sp2    = -1000;
    @(negedge clk);
    reset_a = 1'b0;
    send_a(8'h81);
    wait_idle_a();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      send_a(8'($urandom_range(0, 255)));
    end
    wait_idle_a();
  endtask

  task automatic run_b();
    int s;
    int c;
    int j;
    b_valid = 1'b1;
    b_data  = 8'hFF;
    chk("b_ready_idle", int'(b_ready), 1);
    s = cyc + 2;
    @(negedge clk);
    b_valid = 1'b0;
    do begin
      @(posedge clk);
      #1;
      c = cyc;
      j = c - s;
      chk("b_line", int'(b_uart), int'(frame_bit(8'hFF, (j < 0) ? 10 : j / B_CPB)));
      chk("b_done", int'(b_done), int'(j == B_LEN - 1));
      chk("b_busy", int'(b_busy), int'(c < s + B_LEN));
    end while (c < s + B_LEN + 4);
  endtask

  task automatic send_c(input logic [7:0] d);
    int t;
    c_valid = 1'b1;
    c_data  = d;
    t = 0;
    while (c_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      chk("c_accept_timeout", t, 0);
    end else begin
      sb_c.push_back(d);
      @(negedge clk);
    end
    c_valid = 1'b0;
  endtask

  task automatic run_c();
    logic [7:0] bytes_c [3];
    bytes_c[0] = 8'h00;
    bytes_c[1] = 8'hFF;
    bytes_c[2] = 8'h5A;
    for (int i = 0; i < 3; i++) send_c(bytes_c[i]);
  endtask

  // Behavioural receiver: sample each bit at its centre, check stop bit, pop expected byte.
  task automatic rx_c();
    logic [7:0] got;
    logic [7:0] expv;
    int t;
    got = 8'h00;
    for (int f = 0; f < 3; f++) begin
      t = 0;
      while (c_uart !== 1'b0 && t < 10000) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t >= 10000) begin
        chk("c_rx_start_timeout", t, 0);
        return;
      end
      repeat (C_CPB / 2) begin @(posedge clk); #1; end
      chk("c_rx_start_bit", int'(c_uart), 0);
      for (int i = 0; i < 8; i++) begin
        repeat (C_CPB) begin @(posedge clk); #1; end
        got = {c_uart, got[7:1]};
      end
      repeat (C_CPB) begin @(posedge clk); #1; end
      chk("c_rx_framing", int'(c_uart), 1);
      if (sb_c.size() == 0) begin
        chk("c_rx_unexpected", int'(got), -1);
      end else begin
        expv = sb_c.pop_front();
        chk("c_rx_data", int'(got), int'(expv));
      end
    end
  endtask

  initial begin
    reset_a  = 1'b1;
    reset_bc = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = 8'h00; b_data = 8'h00; c_data = 8'h00;
    repeat (3) @(negedge clk);
    reset_a   = 1'b0;
    reset_bc  = 1'b0;
    a_started = 1'b1;
    fork
      run_a();
      run_b();
      run_c();
      rx_c();
    join
    repeat (4) @(negedge clk);
    chk("a_sb_drained", sb_a.size(), 0);
    chk("c_sb_drained", sb_c.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got cycle %0d, expected completion before it", cyc);
    $fatal(1);
  end

endmodule
